// File: rtl/nco_channel_scheduler_if.sv
// Configuration port of the NCO channel scheduler: valid/ready increment
// requests plus the one-cycle error pulse for out-of-range channels.
interface nco_channel_scheduler_if #(
  parameter int ACC_WIDTH = 20,
  parameter int CHAN_BITS = 2
) ();
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_BITS-1:0] cfg_chan;
  logic [ACC_WIDTH-1:0] cfg_inc;
  logic                 cfg_reset_phase;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_inc, cfg_reset_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_inc, cfg_reset_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/nco_channel_scheduler.sv
// Round-robin NCO: one shared phase adder serves CHANNELS accumulators and
// emits a one-cycle enable per channel on accumulator overflow.
module nco_channel_scheduler #(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 20,
  parameter int CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  nco_channel_scheduler_if.slave cfg,
  output logic [CHAN_BITS-1:0] slot,
  output logic [CHANNELS-1:0]  enable
);

  logic [CHAN_BITS-1:0] slot_r;
  logic [CHANNELS-1:0]  enable_r;
  logic                 err_r;
  logic                 pend_valid_r;
  logic [CHAN_BITS-1:0] pend_chan_r;
  logic [ACC_WIDTH-1:0] pend_inc_r;
  logic                 pend_rp_r;
  logic [ACC_WIDTH-1:0] phase_r [CHANNELS];
  logic [ACC_WIDTH-1:0] inc_r   [CHANNELS];

  logic                 accept_s;
  logic                 chan_ok_s;
  logic                 hit_s;
  logic                 apply_s;
  logic [ACC_WIDTH-1:0] inc_eff_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic [CHAN_BITS-1:0] next_slot_s;
  logic [CHANNELS-1:0]  enable_nxt_s;

  assign accept_s  = cfg.cfg_valid && !pend_valid_r;
  assign chan_ok_s = (32'(cfg.cfg_chan) < 32'(CHANNELS));
  assign hit_s     = pend_valid_r && (pend_chan_r == slot_r);
  // While frozen a pending request lands immediately, independent of slot.
  assign apply_s   = pend_valid_r && (!run || (pend_chan_r == slot_r));

  // Shared adder: a pending increment for this slot takes effect in the same slot.
  always_comb begin
    inc_eff_s    = hit_s ? pend_inc_r : inc_r[slot_r];
    sum_s        = {1'b0, phase_r[slot_r]} + {1'b0, inc_eff_s};
    next_slot_s  = (slot_r == CHAN_BITS'(CHANNELS - 1)) ? {CHAN_BITS{1'b0}}
                                                        : slot_r + CHAN_BITS'(1);
    enable_nxt_s = {CHANNELS{1'b0}};
    if (run && !(hit_s && pend_rp_r)) begin
      enable_nxt_s[slot_r] = sum_s[ACC_WIDTH];
    end else begin
      enable_nxt_s = {CHANNELS{1'b0}};
    end
  end

  // Slot counter, enable/error outputs and the single pending request slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r       <= {CHAN_BITS{1'b0}};
      enable_r     <= {CHANNELS{1'b0}};
      err_r        <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_chan_r  <= {CHAN_BITS{1'b0}};
      pend_inc_r   <= {ACC_WIDTH{1'b0}};
      pend_rp_r    <= 1'b0;
    end else begin
      err_r    <= accept_s && !chan_ok_s;
      enable_r <= enable_nxt_s;
      if (run) begin
        slot_r <= next_slot_s;
      end else begin
        slot_r <= slot_r;
      end
      if (accept_s && chan_ok_s) begin
        pend_valid_r <= 1'b1;
        pend_chan_r  <= cfg.cfg_chan;
        pend_inc_r   <= cfg.cfg_inc;
        pend_rp_r    <= cfg.cfg_reset_phase;
      end else if (apply_s) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  // Per-channel phase and increment storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        phase_r[i] <= {ACC_WIDTH{1'b0}};
        inc_r[i]   <= {ACC_WIDTH{1'b0}};
      end
    end else begin
      if (apply_s) begin
        inc_r[pend_chan_r] <= pend_inc_r;
      end
      if (run && !(hit_s && pend_rp_r)) begin
        phase_r[slot_r] <= sum_s[ACC_WIDTH-1:0];
      end else if (apply_s && pend_rp_r) begin
        phase_r[pend_chan_r] <= {ACC_WIDTH{1'b0}};
      end
    end
  end

  assign cfg.cfg_ready = !pend_valid_r;
  assign cfg.cfg_err   = err_r;
  assign slot          = slot_r;
  assign enable        = enable_r;

endmodule

// File: tb/tb_nco_channel_scheduler.sv
// Bench for nco_channel_scheduler: a 4-channel and a 3-channel instance share
// stimulus and are compared against an arithmetic model of the channel rules.
module tb_nco_channel_scheduler;
  localparam int W = 20;
  localparam longint unsigned MOD = 64'd1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic v = 1'b0;
  logic rp = 1'b0;
  logic [1:0] ch = 2'd0;
  logic [W-1:0] inc = '0;

  logic [1:0] slot4, slot3;
  logic [3:0] en4;
  logic [2:0] en3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nco_channel_scheduler_if #(.ACC_WIDTH(W), .CHAN_BITS(2)) if4 ();
  nco_channel_scheduler_if #(.ACC_WIDTH(W), .CHAN_BITS(2)) if3 ();

  assign if4.cfg_valid = v;
  assign if4.cfg_chan = ch;
  assign if4.cfg_inc = inc;
  assign if4.cfg_reset_phase = rp;
  assign if3.cfg_valid = v;
  assign if3.cfg_chan = ch;
  assign if3.cfg_inc = inc;
  assign if3.cfg_reset_phase = rp;

  nco_channel_scheduler #(.CHANNELS(4), .ACC_WIDTH(W), .CHAN_BITS(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg(if4.slave), .slot(slot4), .enable(en4)
  );
  nco_channel_scheduler #(.CHANNELS(3), .ACC_WIDTH(W), .CHAN_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg(if3.slave), .slot(slot3), .enable(en3)
  );

  // Reference model, index 0 = 4-channel instance, index 1 = 3-channel instance
  int nch [2] = '{4, 3};
  longint unsigned m_phase [2][16];
  longint unsigned m_inc [2][16];
  int m_slot [2];
  int unsigned m_en [2];
  bit m_err [2];
  bit m_pv [2];
  bit m_prp [2];
  bit m_acc [2];
  int m_pch [2];
  longint unsigned m_pinc [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 16; c++) begin
        m_phase[d][c] = 0;
        m_inc[d][c] = 0;
      end
      m_slot[d] = 0; m_en[d] = 0; m_err[d] = 0; m_pv[d] = 0;
      m_prp[d] = 0; m_acc[d] = 0; m_pch[d] = 0; m_pinc[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int n, s;
    bit acc, accumulate;
    longint unsigned sum;
    n = nch[d];
    s = m_slot[d];
    acc = v && !m_pv[d];
    m_acc[d] = acc;
    m_err[d] = acc && (int'(ch) >= n);
    m_en[d] = 0;
    accumulate = run;
    if (m_pv[d] && (!run || m_pch[d] == s)) begin
      m_inc[d][m_pch[d]] = m_pinc[d];
      m_pv[d] = 0;
      if (m_prp[d]) begin
        m_phase[d][m_pch[d]] = 0;
        accumulate = 0;
      end
    end
    if (accumulate) begin
      sum = m_phase[d][s] + m_inc[d][s];
      if (sum >= MOD) begin
        m_en[d] = 32'd1 << s;
        sum = sum - MOD;
      end
      m_phase[d][s] = sum;
    end
    if (run) m_slot[d] = (s + 1) % n;
    if (acc && int'(ch) < n) begin
      m_pv[d] = 1; m_pch[d] = int'(ch); m_pinc[d] = inc; m_prp[d] = rp;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic send_cfg(input int c, input int unsigned value, input bit r);
    bit done = 0;
    v = 1'b1; ch = 2'(c); inc = W'(value); rp = r;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = m_acc[0];
    end
    v = 1'b0; rp = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_cfg timeout: accepted=%0d required=1", done);
    end
  endtask

  task automatic test_reset();
    run = 1'b1;
    send_cfg(0, 300000, 0);
    repeat (10) cycle();
    for (int i = 0; i < 8 && m_pv[0]; i++) cycle();
    v = 1'b1; ch = 2'd2; inc = W'(12345);
    for (int i = 0; i < 8 && !m_acc[0]; i++) cycle();
    v = 1'b0;
    checks++;
    if (if4.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL reset_pending_ready: got %b want 0", if4.cfg_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks += 8;
    if (slot4 !== 2'd0) begin failures++; $display("FAIL reset_slot4: got %0d want 0", slot4); end
    if (en4 !== 4'd0) begin failures++; $display("FAIL reset_en4: got %b want 0", en4); end
    if (if4.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready4: got %b want 1", if4.cfg_ready); end
    if (if4.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err4: got %b want 0", if4.cfg_err); end
    if (slot3 !== 2'd0) begin failures++; $display("FAIL reset_slot3: got %0d want 0", slot3); end
    if (en3 !== 3'd0) begin failures++; $display("FAIL reset_en3: got %b want 0", en3); end
    if (if3.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready3: got %b want 1", if3.cfg_ready); end
    if (if3.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err3: got %b want 0", if3.cfg_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks += 3;
      if (en4 !== 4'd0 || en3 !== 3'd0) begin
        failures++; $display("FAIL post_reset_quiet: en4=%b en3=%b want 0", en4, en3);
      end
      if (slot4 !== 2'(m_slot[0])) begin failures++; $display("FAIL post_reset_slot4: got %0d want %0d", slot4, m_slot[0]); end
      if (if4.cfg_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready4: got %b want 1", if4.cfg_ready); end
    end
  endtask

  task automatic test_single();
    int last, pulses;
    last = -1; pulses = 0;
    run = 1'b1;
    send_cfg(0, 524288, 0);
    for (int t = 0; t < 64; t++) begin
      cycle();
      checks += 2;
      if (en4 !== 4'(m_en[0])) begin failures++; $display("FAIL single_model: got %b want %b", en4, 4'(m_en[0])); end
      if (en4[3:1] !== 3'd0) begin failures++; $display("FAIL single_others: got %b want 000", en4[3:1]); end
      if (en4[0]) begin
        pulses++;
        checks++;
        if (slot4 !== 2'd1) begin failures++; $display("FAIL single_pulse_slot: got %0d want 1", slot4); end
        if (last >= 0) begin
          checks++;
          if (t - last != 8) begin failures++; $display("FAIL single_interval: got %0d want 8", t - last); end
        end
        last = t;
      end
    end
    checks++;
    if (pulses != 8) begin failures++; $display("FAIL single_count: got %0d want 8", pulses); end
  endtask

  task automatic test_mixed();
    int cnt [4];
    int unsigned rates [4] = '{524288, 262144, 0, 1048575};
    int want [4] = '{8, 4, 0, 16};
    run = 1'b1;
    for (int c = 0; c < 4; c++) send_cfg(c, rates[c], 1);
    repeat (8) cycle();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int t = 0; t < 64; t++) begin
      cycle();
      checks += 2;
      if (en4 !== 4'(m_en[0])) begin failures++; $display("FAIL mixed_model: got %b want %b", en4, 4'(m_en[0])); end
      if ($countones(en4) > 1) begin failures++; $display("FAIL mixed_onehot: got %b want at most one bit", en4); end
      for (int c = 0; c < 4; c++) if (en4[c]) cnt[c]++;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt[c] != want[c]) begin failures++; $display("FAIL mixed_count ch%0d: got %0d want %0d", c, cnt[c], want[c]); end
    end
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    logic want_ready [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int want_slot [6] = '{0, 1, 2, 3, 0, 1};
    run = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_slot[0] == 3 && !m_pv[0]) found = 1;
      else cycle();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL b2b_wait_slot3: found=%0d want 1", found); end
    v = 1'b1; ch = 2'd2; inc = W'(100000); rp = 1'b0;
    cycle();
    checks++;
    if (!m_acc[0] || if4.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_first_accept: ready=%b want 0", if4.cfg_ready);
    end
    inc = W'(200000);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) v = 1'b0;
      checks += 2;
      if (if4.cfg_ready !== want_ready[i]) begin
        failures++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, if4.cfg_ready, want_ready[i]);
      end
      if (slot4 !== 2'(want_slot[i])) begin
        failures++; $display("FAIL b2b_slot[%0d]: got %0d want %0d", i, slot4, want_slot[i]);
      end
      cycle();
    end
  endtask

  task automatic test_phase_reset();
    int first;
    run = 1'b1;
    send_cfg(1, 262144, 0);
    repeat (40) cycle();
    send_cfg(1, 262144, 1);
    for (int i = 0; i < 8 && m_pv[0]; i++) cycle();
    checks += 2;
    if (m_pv[0]) begin failures++; $display("FAIL phase_reset_apply_timeout: pending=%0d want 0", m_pv[0]); end
    if (en4[1] !== 1'b0) begin failures++; $display("FAIL phase_reset_no_pulse: got %b want 0", en4[1]); end
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if (en4 !== 4'(m_en[0])) begin failures++; $display("FAIL phase_reset_model: got %b want %b", en4, 4'(m_en[0])); end
      if (en4[1] && first < 0) first = i;
    end
    checks++;
    if (first != 16) begin failures++; $display("FAIL phase_reset_next_pulse: got %0d want 16", first); end
  endtask

  task automatic test_freeze_invalid();
    int hold;
    run = 1'b1;
    for (int i = 0; i < 16 && (m_pv[0] || m_pv[1]); i++) cycle();
    run = 1'b0;
    cycle();
    hold = m_slot[1];
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks += 2;
      if (slot3 !== 2'(hold)) begin failures++; $display("FAIL freeze_slot: got %0d want %0d", slot3, hold); end
      if (en3 !== 3'd0 || en4 !== 4'd0) begin failures++; $display("FAIL freeze_enable: en3=%b en4=%b want 0", en3, en4); end
    end
    v = 1'b1; ch = 2'd0; inc = W'(700000);
    cycle();
    v = 1'b0;
    checks++;
    if (if3.cfg_ready !== 1'b0) begin failures++; $display("FAIL freeze_accept_ready: got %b want 0", if3.cfg_ready); end
    cycle();
    checks++;
    if (if3.cfg_ready !== 1'b1) begin failures++; $display("FAIL freeze_apply_1cycle: got %b want 1", if3.cfg_ready); end
    v = 1'b1; ch = 2'd3; inc = W'(999);
    cycle();
    v = 1'b0;
    checks += 3;
    if (if3.cfg_err !== 1'b1) begin failures++; $display("FAIL invalid_err_pulse: got %b want 1", if3.cfg_err); end
    if (if3.cfg_ready !== 1'b1) begin failures++; $display("FAIL invalid_ready: got %b want 1", if3.cfg_ready); end
    if (if4.cfg_err !== 1'b0) begin failures++; $display("FAIL valid_no_err4: got %b want 0", if4.cfg_err); end
    cycle();
    checks += 2;
    if (if3.cfg_err !== 1'b0) begin failures++; $display("FAIL invalid_err_once: got %b want 0", if3.cfg_err); end
    if (slot3 !== 2'(hold)) begin failures++; $display("FAIL freeze_slot_end: got %0d want %0d", slot3, hold); end
    run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks += 2;
      if (en3 !== 3'(m_en[1])) begin failures++; $display("FAIL after_invalid_en3: got %b want %b", en3, 3'(m_en[1])); end
      if (if3.cfg_ready !== !m_pv[1]) begin failures++; $display("FAIL after_invalid_ready3: got %b want %b", if3.cfg_ready, !m_pv[1]); end
    end
  endtask

  task automatic test_random();
    int unsigned kind;
    for (int t = 0; t < 800; t++) begin
      run = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 3) == 0);
      ch = 2'($urandom_range(0, 3));
      rp = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 4);
      case (kind)
        0: inc = '0;
        1: inc = '1;
        2: inc = W'(32'd1 << $urandom_range(15, 19));
        default: inc = W'($urandom);
      endcase
      cycle();
      checks += 8;
      if (slot4 !== 2'(m_slot[0])) begin failures++; $display("FAIL rand_slot4 t=%0d: got %0d want %0d", t, slot4, m_slot[0]); end
      if (en4 !== 4'(m_en[0])) begin failures++; $display("FAIL rand_en4 t=%0d: got %b want %b", t, en4, 4'(m_en[0])); end
      if (if4.cfg_ready !== !m_pv[0]) begin failures++; $display("FAIL rand_ready4 t=%0d: got %b want %b", t, if4.cfg_ready, !m_pv[0]); end
      if (if4.cfg_err !== m_err[0]) begin failures++; $display("FAIL rand_err4 t=%0d: got %b want %b", t, if4.cfg_err, m_err[0]); end
      if (slot3 !== 2'(m_slot[1])) begin failures++; $display("FAIL rand_slot3 t=%0d: got %0d want %0d", t, slot3, m_slot[1]); end
      if (en3 !== 3'(m_en[1])) begin failures++; $display("FAIL rand_en3 t=%0d: got %b want %b", t, en3, 3'(m_en[1])); end
      if (if3.cfg_ready !== !m_pv[1]) begin failures++; $display("FAIL rand_ready3 t=%0d: got %b want %b", t, if3.cfg_ready, !m_pv[1]); end
      if (if3.cfg_err !== m_err[1]) begin failures++; $display("FAIL rand_err3 t=%0d: got %b want %b", t, if3.cfg_err, m_err[1]); end
    end
    v = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_mixed();
    test_back_to_back();
    test_phase_reset();
    test_freeze_invalid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nco_channel_scheduler.md
# nco_channel_scheduler

Time-multiplexed NCO scheduler: shares one ACC_WIDTH-bit phase adder across CHANNELS independent channels in fixed round-robin order. Each channel produces a one-cycle enable pulse on accumulator overflow. Per-channel increments are programmed through a valid/ready config port, and updates are applied atomically in the channel's own slot. It sits between the system clock and downstream clock-enable consumers (pixel, audio and UART timing) as the configurable, multi-output replacement for single fixed-rate enable generators.

## Interface
- CHANNELS, 4, number of channels, 2..16
- ACC_WIDTH, 20, phase accumulator and increment width
- CHAN_BITS, $clog2(CHANNELS) (min 1), channel index width
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1: slots advance and accumulate; 0: frozen
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config request can be accepted
- cfg_chan  in  CHAN_BITS  target channel
- cfg_inc  in  ACC_WIDTH  new increment for target channel
- cfg_reset_phase  in  1  also clear the target channel's phase when applied
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_chan >= CHANNELS
- slot  out  CHAN_BITS  channel processed this cycle
- enable  out  CHANNELS  per-channel enable pulses; at most one bit high per cycle

## Operation
- Storage: phase[CHANNELS] and inc[CHANNELS], each ACC_WIDTH bits. One pending register holds {chan, inc, reset_phase, pend_valid}.
- Slot counter: advances 0,1,…,CHANNELS-1,0 each cycle while run=1 and holds while run=0. `slot` is the counter's register output.
- Accumulate, when run=1 for channel s=slot: {carry, phase[s]} <= phase[s] + inc_eff, with the sum ACC_WIDTH+1 bits wide and the carry being the MSB. enable[s] <= carry; all other enable bits <= 0.
  - inc_eff = pending inc if pend_valid and pending chan == s; otherwise inc[s].
- Output rate per channel: f_clk * inc / (2^ACC_WIDTH * CHANNELS). inc=0 gives no pulses. The maximum is inc = 2^ACC_WIDTH-1.
- Handshake: cfg_ready = !pend_valid. A transfer occurs when cfg_valid and cfg_ready are both high on a rising edge.
  - If cfg_chan >= CHANNELS: nothing is stored and cfg_err pulses the next cycle. cfg_ready stays 1.
  - Otherwise the request is captured into pending and pend_valid becomes 1.
- Apply (run=1): in the first cycle where slot == pending chan, inc[chan] <= pending inc and pend_valid clears.
  - If reset_phase=1: phase[chan] <= 0 and enable[chan] <= 0 for that slot, with no accumulation.
  - Otherwise the slot accumulates using the new inc.
- Apply (run=0): applied on the first cycle after capture, regardless of slot, with no accumulation. A reset_phase request clears the phase.
- A run transition 1->0 mid-cycle takes effect from the next edge. The enable pulse already registered still appears.

## Timing
- Reset values (async, on rst_n low): slot=0, enable=0, cfg_err=0, cfg_ready=1, pend_valid=0, all phase=0, all inc=0. A reset while a request is pending drops the request.
- Enable latency: enable[s] is high in the cycle after the slot==s cycle that overflowed, i.e. while slot == (s+1) mod CHANNELS.
- Config latency: from acceptance edge to inc update is 1..CHANNELS cycles when run=1, and exactly 1 cycle when run=0.
  - cfg_ready rises in the cycle after apply, so back-to-back requests are spaced at least 2 cycles apart.
- Simultaneous accept and apply cannot occur (ready low while pending).
- Phase arithmetic wraps modulo 2^ACC_WIDTH. The carry is never lost, and the residue is kept in phase.

## Test plan
- Reset: assert rst_n=0 mid-run with a request pending -> immediately slot=0, enable=0, cfg_ready=1, cfg_err=0. After release, no pulses until configured.
- Single channel (CHANNELS=4, ACC_WIDTH=20): program ch0 inc=524288 with run=1 -> enable[0] pulses every 8 cycles, always while slot=1. Other enable bits stay 0.
- Mixed rates: ch0=524288, ch1=262144, ch2=0, ch3=1048575 -> over 64 cycles, counts are 8, 4, 0, 16 respectively (ch3 pulses on every visit after the first). Never more than one enable bit is high.
- Back-to-back config: hold cfg_valid for two requests to ch2 while slot=3 -> first applies at slot=2 (3 cycles later). cfg_ready is low for exactly that span, and the second request is accepted only after ready returns.
- Phase reset: ch1 inc=262144 running, then send inc=262144 with cfg_reset_phase=1 -> no pulse at the apply slot; next pulse exactly 16 cycles after apply.
- Freeze and invalid channel (CHANNELS=3): run=0 -> slot holds, enable=0; a request for ch0 applies 1 cycle after acceptance. A request with cfg_chan=3 -> cfg_err pulses once, and no inc changes.
